// File: rtl/clock_time_core.sv
// Time-keeping core: 1 Hz prescaler, BCD hh:mm:ss counter and key-driven set mode.
// Packed BCD time feeds the 6-digit scan driver directly.
module clock_time_core #(
  parameter int unsigned CNT_MAX = 49_999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [23:0] disp_data,
  output logic [1:0]  set_mode,
  output logic        tick_1hz
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } mode_e;

  localparam logic [25:0] CNT_TOP = 26'(CNT_MAX);

  mode_e       mode_q, mode_d;
  logic [25:0] cnt_q, cnt_d;
  logic [7:0]  hr_q, hr_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  sec_q, sec_d;
  logic        tick_q, tick_d;

  // Two-digit BCD increment wrapping at lim; any out-of-range value recovers to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v >= lim) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    unique case (m)
      RUN:     r = SET_HR;
      SET_HR:  r = SET_MIN;
      SET_MIN: r = SET_SEC;
      default: r = RUN;
    endcase
    return r;
  endfunction

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    hr_d   = hr_q;
    min_d  = min_q;
    sec_d  = sec_q;
    tick_d = 1'b0;
    if (key_mode) begin
      // A mode key always wins over a simultaneous increment and restarts the prescaler.
      mode_d = next_mode(mode_q);
      cnt_d  = '0;
    end else begin
      unique case (mode_q)
        RUN: begin
          if (cnt_q == CNT_TOP) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sec_d  = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
              min_d = bcd_inc(min_q, 8'h59);
              if (min_q == 8'h59) begin
                hr_d = bcd_inc(hr_q, 8'h23);
              end
            end
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        SET_HR: begin
          cnt_d = '0;
          if (key_inc) hr_d = bcd_inc(hr_q, 8'h23);
        end
        SET_MIN: begin
          cnt_d = '0;
          if (key_inc) min_d = bcd_inc(min_q, 8'h59);
        end
        default: begin
          cnt_d = '0;
          if (key_inc) sec_d = bcd_inc(sec_q, 8'h59);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= RUN;
      cnt_q  <= '0;
      hr_q   <= 8'h00;
      min_q  <= 8'h00;
      sec_q  <= 8'h00;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      hr_q   <= hr_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      tick_q <= tick_d;
    end
  end

  assign disp_data = {hr_q, min_q, sec_q};
  assign set_mode  = mode_q;
  assign tick_1hz  = tick_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Scoreboard bench for clock_time_core: stimulus pushes expected {disp_data,set_mode},
// a negedge monitor pops on every visible output change and checks tick_1hz alignment.
module tb_clock_time_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode;
  logic        key_inc;
  logic [23:0] disp_data;
  logic [1:0]  set_mode;
  logic        tick_1hz;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic [25:0] exp_q[$];

  clock_time_core #(.CNT_MAX(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .disp_data (disp_data),
    .set_mode  (set_mode),
    .tick_1hz  (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic expect_out(input logic [23:0] d, input logic [1:0] m);
    exp_q.push_back({d, m});
  endtask

  task automatic press(input logic md, input logic inc, input logic [23:0] ed, input logic [1:0] em);
    @(negedge clk);
    expect_out(ed, em);
    key_mode = md;
    key_inc  = inc;
    @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
  endtask

  // Monitor: every output change must match the next queued expectation.
  initial begin
    logic [23:0] prev_disp;
    logic [1:0]  prev_mode;
    logic        init_done;
    logic [25:0] e;
    init_done = 1'b0;
    prev_disp = '0;
    prev_mode = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (init_done) begin
          check("tick_1hz_align", {31'd0, tick_1hz},
                {31'd0, (disp_data != prev_disp) && (prev_mode == 2'b00) && (set_mode == 2'b00)});
          if ({disp_data, set_mode} != {prev_disp, prev_mode}) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_change: actual %h/%b required %h/%b",
                       disp_data, set_mode, prev_disp, prev_mode);
            end else begin
              e = exp_q.pop_front();
              check("disp_data", {8'd0, disp_data}, {8'd0, e[25:2]});
              check("set_mode", {30'd0, set_mode}, {30'd0, e[1:0]});
            end
          end
        end
        prev_disp = disp_data;
        prev_mode = set_mode;
        init_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_disp", {8'd0, disp_data}, 32'h0);
    check("reset_mode", {30'd0, set_mode}, 32'h0);
    check("reset_tick", {31'd0, tick_1hz}, 32'h0);
    mon_en = 1'b1;

    // Free run from reset; key_inc in RUN must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    expect_out(24'h000001, 2'b00);
    expect_out(24'h000002, 2'b00);
    expect_out(24'h000003, 2'b00);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      key_inc = (i == 3);
      if (i == 9)  check("first_step_early", {8'd0, disp_data}, 32'h000000);
      if (i == 10) begin
        check("first_step", {8'd0, disp_data}, 32'h000001);
        check("first_tick", {31'd0, tick_1hz}, 32'h1);
      end
      if (i == 11) check("tick_one_cycle", {31'd0, tick_1hz}, 32'h0);
    end

    // Hours: 25 increments wrap 23 -> 00 and land on 01.
    press(1'b1, 1'b0, 24'h000003, 2'b01);
    for (int h = 1; h <= 25; h++) press(1'b0, 1'b1, {bcd(h % 24), 8'h00, 8'h03}, 2'b01);
    for (int h = 2; h <= 23; h++) press(1'b0, 1'b1, {bcd(h), 8'h00, 8'h03}, 2'b01);
    // Simultaneous mode+inc: mode advances, hours untouched.
    press(1'b1, 1'b1, 24'h230003, 2'b10);

    // Minutes roll 59 -> 00 without carry, then set to 59.
    for (int m = 1; m <= 60; m++) press(1'b0, 1'b1, {8'h23, bcd(m % 60), 8'h03}, 2'b10);
    for (int m = 1; m <= 59; m++) press(1'b0, 1'b1, {8'h23, bcd(m), 8'h03}, 2'b10);

    // Seconds roll 59 -> 00 without carry, then set to 58.
    press(1'b1, 1'b0, 24'h235903, 2'b11);
    for (int s = 4; s <= 60; s++) press(1'b0, 1'b1, {8'h23, 8'h59, bcd(s % 60)}, 2'b11);
    for (int s = 1; s <= 58; s++) press(1'b0, 1'b1, {8'h23, 8'h59, bcd(s)}, 2'b11);

    // Back to RUN: first advance CNT_MAX+1 cycles after the transition edge.
    press(1'b1, 1'b0, 24'h235958, 2'b00);
    expect_out(24'h235959, 2'b00);
    expect_out(24'h000000, 2'b00);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 9)  check("restart_early", {8'd0, disp_data}, 32'h235958);
      if (i == 10) check("restart_step", {8'd0, disp_data}, 32'h235959);
      if (i == 20) check("day_rollover", {8'd0, disp_data}, 32'h000000);
    end

    // Set 12:34:56 and park in SET_MIN.
    press(1'b1, 1'b0, 24'h000000, 2'b01);
    for (int h = 1; h <= 12; h++) press(1'b0, 1'b1, {bcd(h), 8'h00, 8'h00}, 2'b01);
    press(1'b1, 1'b0, 24'h120000, 2'b10);
    for (int m = 1; m <= 34; m++) press(1'b0, 1'b1, {8'h12, bcd(m), 8'h00}, 2'b10);
    press(1'b1, 1'b0, 24'h123400, 2'b11);
    for (int s = 1; s <= 56; s++) press(1'b0, 1'b1, {8'h12, 8'h34, bcd(s)}, 2'b11);
    press(1'b1, 1'b0, 24'h123456, 2'b00);
    press(1'b1, 1'b0, 24'h123456, 2'b01);
    press(1'b1, 1'b0, 24'h123456, 2'b10);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #2;
    expect_out(24'h000000, 2'b00);
    rst_n = 1'b0;
    #1;
    check("async_rst_disp", {8'd0, disp_data}, 32'h0);
    check("async_rst_mode", {30'd0, set_mode}, 32'h0);
    check("async_rst_tick", {31'd0, tick_1hz}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_out(24'h000001, 2'b00);
    expect_out(24'h000002, 2'b00);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) check("post_rst_step1", {8'd0, disp_data}, 32'h000001);
      if (i == 20) check("post_rst_step2", {8'd0, disp_data}, 32'h000002);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
- Time-keeping core of the digital clock.
- Divides the system clock down to a 1 Hz tick and keeps hours:minutes:seconds as six BCD digits.
- Lets the user set each field through debounced key pulses.
- Its packed 24-bit BCD output feeds the 6-digit 7-segment scan driver directly downstream.

Parameters:
- CNT_MAX, 49_999_999: terminal count of the 1 Hz prescaler (CLK period × (CNT_MAX+1) = 1 s at 50 MHz); benches use a small value, e.g. 9.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- key_mode  input  1  single-cycle active-high pulse from upstream debouncer; advances set-mode state
- key_inc  input  1  single-cycle active-high pulse from upstream debouncer; increments the field being set
- disp_data  output  24  {hr_tens, hr_units, min_tens, min_units, sec_tens, sec_units}, 4-bit BCD each; [3:0] = seconds units (rightmost digit)
- set_mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
- tick_1hz  output  1  one-cycle pulse, high in the cycle after the time advanced in RUN

Behaviour:
- Reset (async, rst_n low):
  - All six digits = 0, so disp_data = 24'h000000 (00:00:00).
  - set_mode = 00 (RUN), prescaler = 0, tick_1hz = 0.
  - All state flops are asynchronously reset; outputs are registered.
- Prescaler:
  - 26-bit counter. In RUN it increments each clk.
  - At the edge where cnt == CNT_MAX, cnt goes to 0 and the time advances on that same edge.
  - In any SET state cnt is held at 0.
- Time advance (RUN only, once per prescaler wrap):
  - Seconds units 9 -> 0 with carry into tens; seconds 59 -> 00 with carry into minutes.
  - Minutes 59 -> 00 with carry into hours; hours 23 -> 00.
  - All carries resolve on a single edge: 23:59:59 -> 00:00:00 in one step.
- tick_1hz: registered, high for exactly the one cycle following each time advance; never asserted outside RUN.
- FSM transitions on key_mode:
  - RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
  - The transition takes effect on the edge that samples key_mode.
- key_inc in SET_HR:
  - Hours +1 BCD, 23 -> 00.
  - No carry into or out of other fields.
- key_inc in SET_MIN:
  - Minutes +1 BCD, 59 -> 00.
  - No carry into or out of other fields.
- key_inc in SET_SEC:
  - Seconds +1 BCD, 59 -> 00.
  - No carry into or out of other fields.
- key_inc in RUN: ignored.
- Simultaneous key_mode and key_inc: key_mode wins; the increment is discarded.
- Entering any SET state freezes time; the prescaler is cleared on the same edge.
- Leaving SET_SEC -> RUN:
  - Prescaler restarts from 0.
  - First advance occurs CNT_MAX+1 cycles after the transition edge.
- Robustness:
  - Any field found out of range when incremented (hours > 23, minutes or seconds > 59, or a units digit > 9) loads 0 for that field.
  - Out-of-range values cannot arise from legal operation.
- Reset asserted mid-set or mid-count: immediate return to the reset state, without waiting for a clock edge.
- Latency: disp_data reflects an advance or increment one clk after the causing edge condition is sampled. disp_data is stable between updates.

Test Plan:
- Reset, CNT_MAX=9, run 30 cycles:
  - disp_data 000000 -> 000001 -> 000002 -> 000003, one step every 10 cycles.
  - tick_1hz high one cycle after each step.
- Preload to 23:59:58 via SET mode, return to RUN, run 20 cycles:
  - 235959, then 000000.
  - All carries on a single edge.
- key_mode ×1 then key_inc ×25:
  - hours count 01..23, then wrap to 00, then 01.
  - set_mode = 01.
  - Minutes and seconds unchanged.
  - No tick_1hz while in SET.
- Minute rollover in SET_MIN from 59, and seconds rollover in SET_SEC from 59:
  - Each field goes to 00.
  - The neighbouring field is unchanged (no carry).
- key_mode and key_inc asserted in the same cycle in SET_HR:
  - set_mode -> 10.
  - Hours unchanged.
- rst_n pulsed low asynchronously (mid-cycle) while in SET_MIN with time 12:34:56:
  - Outputs read 000000 and set_mode = 00 before the next clk edge.
  - Counting resumes normally after release.
